// File: rtl/drum_pkg.sv
// Shared encodings and constants for the drum sequencer.
// The tempo threshold is a function of the clock rate so each instance derives its own.
package drum_pkg;

    localparam int unsigned STEPS = 8;

    // Encoding doubles as the externally visible state_id.
    typedef enum logic [2:0] {
        PLAY   = 3'd0,
        LD_I1  = 3'd1,
        LD_I2  = 3'd2,
        LD_I3  = 3'd3,
        LD_I4  = 3'd4,
        LD_BPM = 3'd5
    } state_t;

    // One eighth note elapses when 2*bpm has been summed 60*CLK_HZ times over.
    function automatic logic [31:0] tick_threshold(input int unsigned clk_hz);
        longint unsigned t;
        t = 64'(clk_hz) * 64'd60;
        return t[31:0];
    endfunction

endpackage

// File: rtl/tempo_tick.sv
// Phase-accumulator tempo generator: one-cycle tick per eighth note at bpm.
// Tick is registered (1 cycle after the crossing add); en low clears the phase.
module tempo_tick
    import drum_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] bpm,
    output logic       tick
);

    localparam logic [31:0] THRESH = tick_threshold(CLK_HZ);

    logic [31:0] acc;
    logic [31:0] sum;

    assign sum = acc + 32'({bpm, 1'b0});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (!en) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (sum >= THRESH) begin
            acc  <= sum - THRESH;
            tick <= 1'b1;
        end else begin
            acc  <= sum;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/drum_sequencer.sv
// Four-instrument, eight-step drum sequencer: load four patterns and a bpm, then play.
// All outputs registered; go advances the FSM and overrides a coincident tick.
module drum_sequencer #(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned STEPS  = drum_pkg::STEPS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic [7:0] sel,
    output logic [2:0] state_id,
    output logic [3:0] hits,
    output logic [2:0] step,
    output logic       tick,
    output logic       playing
);

    import drum_pkg::*;

    state_t     state, state_nxt;
    logic [7:0] pat [4];
    logic [7:0] bpm_r;
    logic [2:0] step_inc;
    logic       tempo_en;
    logic       tick_w;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= LD_I1;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (go) begin
            unique case (state)
                LD_I1:   state_nxt = LD_I2;
                LD_I2:   state_nxt = LD_I3;
                LD_I3:   state_nxt = LD_I4;
                LD_I4:   state_nxt = LD_BPM;
                LD_BPM:  state_nxt = PLAY;
                PLAY:    state_nxt = LD_I1;
                default: state_nxt = LD_I1;
            endcase
        end
    end

    assign state_id = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) pat[i] <= '0;
            bpm_r <= '0;
        end else if (go) begin
            unique case (state)
                LD_I1:   pat[0] <= sel;
                LD_I2:   pat[1] <= sel;
                LD_I3:   pat[2] <= sel;
                LD_I4:   pat[3] <= sel;
                LD_BPM:  bpm_r  <= sel;
                default: ;
            endcase
        end
    end

    // Holding the generator disabled outside PLAY also clears the phase on entry.
    assign tempo_en = (state == PLAY) && !go;

    tempo_tick #(.CLK_HZ(CLK_HZ)) u_tempo (
        .clk   (clk),
        .reset (reset),
        .en    (tempo_en),
        .bpm   (bpm_r),
        .tick  (tick_w)
    );

    assign tick     = tick_w;
    assign step_inc = (32'(step) == STEPS - 1) ? 3'd0 : step + 3'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step    <= '0;
            hits    <= '0;
            playing <= 1'b0;
        end else begin
            hits    <= '0;
            playing <= (state_nxt == PLAY);
            if (state == LD_BPM && go) begin
                step <= '0;
                for (int i = 0; i < 4; i++) hits[i] <= pat[i][0];
            end else if (state == PLAY && go) begin
                step <= '0;
            end else if (state == PLAY && tick_w) begin
                step <= step_inc;
                for (int i = 0; i < 4; i++) hits[i] <= pat[i][step_inc];
            end
        end
    end

endmodule
